// File: rtl/mem_stage_unit_if.sv
// Data-memory request/acknowledge bundle between the MEM stage and the data memory.
// The stage drives the request side; the memory answers with ack and read data.
interface mem_stage_unit_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wdata_o,
    input  dmem_ack_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wdata_o,
    output dmem_ack_i,
    output dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM stage: branch/jump redirect, variable-latency load/store handshake,
// upstream stall generation and the MEM/WB pipeline register.
module mem_stage_unit (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     MemtoReg_i,
  input  logic                     Regwrite_i,
  input  logic                     Memread_i,
  input  logic                     Memwrite_i,
  input  logic                     Branch_i,
  input  logic                     BranchType_i,
  input  logic                     Jump_i,
  input  logic                     zero_i,
  input  logic [31:0]              pc_branch_i,
  input  logic [31:0]              pc_jump_i,
  input  logic [31:0]              ALU_result_i,
  input  logic [31:0]              write_data_i,
  input  logic [4:0]               Reg_addr_i,
  mem_stage_unit_if.master         dmem,
  output logic                     stall_o,
  output logic                     pc_src_o,
  output logic [31:0]              pc_target_o,
  output logic                     flush_o,
  output logic                     err_o,
  output logic                     Regwrite_o,
  output logic                     MemtoReg_o,
  output logic [4:0]               Reg_addr_o,
  output logic [31:0]              ALU_result_o,
  output logic [31:0]              read_data_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] rdata_q;

  logic access;
  logic misaligned;
  logic go;
  logic st_idle;
  logic st_busy;
  logic st_done;
  logic req;
  logic taken;

  assign access     = Memread_i | Memwrite_i;
  assign misaligned = access & (ALU_result_i[1:0] != 2'b00);
  assign go         = access & ~misaligned;

  assign st_idle = (state_q == IDLE);
  assign st_busy = (state_q == BUSY);
  assign st_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle: if (go) state_d = BUSY;
      st_busy: if (dmem.dmem_ack_i) state_d = DONE;
      st_done: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (st_busy && dmem.dmem_ack_i) begin
      rdata_q <= dmem.dmem_rdata_i;
    end
  end

  // Reset gates the request so an in-flight access is dropped at once,
  // even while the EX/MEM fields still describe the access.
  assign req = rst_n & ((st_idle & go) | st_busy);

  assign dmem.dmem_req_o   = req;
  assign dmem.dmem_we_o    = req & Memwrite_i;
  assign dmem.dmem_addr_o  = ALU_result_i;
  assign dmem.dmem_wdata_o = write_data_i;

  assign stall_o = req;
  assign err_o   = misaligned;

  assign taken       = Branch_i & (zero_i ^ BranchType_i);
  assign pc_src_o    = (Jump_i | taken) & ~stall_o;
  assign pc_target_o = Jump_i ? pc_jump_i : pc_branch_i;
  assign flush_o     = pc_src_o;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      Regwrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      Reg_addr_o   <= '0;
      ALU_result_o <= '0;
      read_data_o  <= '0;
    end else if (stall_o) begin
      Regwrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
    end else begin
      Regwrite_o   <= Regwrite_i & ~misaligned;
      MemtoReg_o   <= MemtoReg_i;
      Reg_addr_o   <= Reg_addr_i;
      ALU_result_o <= ALU_result_i;
      read_data_o  <= rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: per-cycle expectations from an
// instruction-level model, checked by an independent negedge monitor.
module tb_mem_stage_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        MemtoReg_i = 0, Regwrite_i = 0, Memread_i = 0, Memwrite_i = 0;
  logic        Branch_i = 0, BranchType_i = 0, Jump_i = 0, zero_i = 0;
  logic [31:0] pc_branch_i = 0, pc_jump_i = 0, ALU_result_i = 0, write_data_i = 0;
  logic [4:0]  Reg_addr_i = 0;
  logic        stall_o, pc_src_o, flush_o, err_o, Regwrite_o, MemtoReg_o;
  logic [31:0] pc_target_o, ALU_result_o, read_data_o;
  logic [4:0]  Reg_addr_o;

  mem_stage_unit_if dmem();

  mem_stage_unit dut (
    .clk_i(clk), .rst_n(rst_n),
    .MemtoReg_i(MemtoReg_i), .Regwrite_i(Regwrite_i),
    .Memread_i(Memread_i), .Memwrite_i(Memwrite_i),
    .Branch_i(Branch_i), .BranchType_i(BranchType_i),
    .Jump_i(Jump_i), .zero_i(zero_i),
    .pc_branch_i(pc_branch_i), .pc_jump_i(pc_jump_i),
    .ALU_result_i(ALU_result_i), .write_data_i(write_data_i),
    .Reg_addr_i(Reg_addr_i), .dmem(dmem),
    .stall_o(stall_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o),
    .flush_o(flush_o), .err_o(err_o),
    .Regwrite_o(Regwrite_o), .MemtoReg_o(MemtoReg_o),
    .Reg_addr_o(Reg_addr_o), .ALU_result_o(ALU_result_o),
    .read_data_o(read_data_o)
  );

  typedef struct packed {
    logic        req, we, stall, pc_src, flush, err;
    logic [31:0] tgt, addr, wdata;
    logic        rw, m2r;
    logic [4:0]  ra;
    logic [31:0] alu, rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Architectural view of MEM/WB plus the last load data returned by memory.
  logic        m_rw = 0, m_m2r = 0;
  logic [4:0]  m_ra = 0;
  logic [31:0] m_alu = 0, m_rd = 0, m_rdata = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rw = 0; m_m2r = 0; m_ra = 0; m_alu = 0; m_rd = 0; m_rdata = 0;
  endtask

  // One instruction occupies MEM for 1 cycle, or lat+2 cycles for an
  // aligned access acked on its lat-th BUSY cycle.
  task automatic run_instr(input logic mr, mw, rw, m2r, br, bt, jp, z,
                           input logic [31:0] pcb, pcj, alu, wd,
                           input logic [4:0] ra, input int lat,
                           input logic [31:0] data);
    logic ok, mis, redir, st, ack;
    int n;
    exp_t e;
    ok    = (mr | mw) && (alu[1:0] == 2'b00);
    mis   = (mr | mw) && !ok;
    n     = ok ? lat + 2 : 1;
    redir = jp | (br & (z ^ bt));
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      Memread_i = mr; Memwrite_i = mw; Regwrite_i = rw; MemtoReg_i = m2r;
      Branch_i = br; BranchType_i = bt; Jump_i = jp; zero_i = z;
      pc_branch_i = pcb; pc_jump_i = pcj; ALU_result_i = alu;
      write_data_i = wd; Reg_addr_i = ra;
      ack = ok && (k == lat);
      dmem.dmem_ack_i = ack;
      dmem.dmem_rdata_i = ack ? data : $urandom;
      st = ok && (k < n - 1);
      e.req = st; e.we = st & mw; e.stall = st;
      e.pc_src = redir & !st; e.flush = redir & !st; e.err = mis;
      e.tgt = jp ? pcj : pcb; e.addr = alu; e.wdata = wd;
      e.rw = m_rw; e.m2r = m_m2r; e.ra = m_ra; e.alu = m_alu; e.rd = m_rd;
      q.push_back(e);
      if (ack) m_rdata = data;
      if (st) begin
        m_rw = 0; m_m2r = 0;
      end else begin
        m_rw = rw & !mis; m_m2r = m2r; m_ra = ra; m_alu = alu; m_rd = m_rdata;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("comb", 128'({dmem.dmem_req_o, dmem.dmem_we_o, stall_o, pc_src_o,
                          flush_o, err_o, pc_target_o, dmem.dmem_addr_o,
                          dmem.dmem_wdata_o}),
            128'({e.req, e.we, e.stall, e.pc_src, e.flush, e.err,
                  e.tgt, e.addr, e.wdata}));
        chk("memwb", 128'({Regwrite_o, MemtoReg_o, Reg_addr_o, ALU_result_o,
                           read_data_o}),
            128'({e.rw, e.m2r, e.ra, e.alu, e.rd}));
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl"}, 128'({dmem.dmem_req_o, stall_o, pc_src_o, flush_o, err_o}), 128'(0));
    chk({tag, "_memwb"}, 128'({Regwrite_o, MemtoReg_o, Reg_addr_o, ALU_result_o,
                               read_data_o}), 128'(0));
  endtask

  task automatic clear_inputs();
    Memread_i = 0; Memwrite_i = 0; Regwrite_i = 0; MemtoReg_i = 0;
    Branch_i = 0; BranchType_i = 0; Jump_i = 0; zero_i = 0;
    pc_branch_i = 0; pc_jump_i = 0; ALU_result_i = 0; write_data_i = 0;
    Reg_addr_i = 0; dmem.dmem_ack_i = 0; dmem.dmem_rdata_i = 0;
  endtask

  initial begin : stim
    clear_inputs();
    #12;
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // Directed cases: load, delayed store, beq/bne, jump priority, misaligned.
    run_instr(1,0,1,1, 0,0,0,0, 32'h0, 32'h0, 32'h40, 32'h0, 5'd3, 1, 32'hDEADBEEF);
    run_instr(0,0,1,0, 0,0,0,0, 32'h0, 32'h0, 32'h1111, 32'h0, 5'd4, 1, 32'h0);
    run_instr(0,1,0,0, 0,0,0,0, 32'h0, 32'h0, 32'h80, 32'h12345678, 5'd0, 3, 32'h0);
    run_instr(0,0,0,0, 1,0,0,1, 32'h100, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'h0);
    run_instr(0,0,0,0, 1,1,0,1, 32'h100, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'h0);
    run_instr(0,0,0,0, 1,0,1,1, 32'h100, 32'h200, 32'h0, 32'h0, 5'd0, 1, 32'h0);
    run_instr(1,0,1,1, 0,0,0,0, 32'h0, 32'h0, 32'h42, 32'h0, 5'd7, 1, 32'h0);
    run_instr(1,1,1,0, 0,0,0,0, 32'h0, 32'h0, 32'h84, 32'hCAFEF00D, 5'd8, 2, 32'h55AA55AA);
    run_instr(0,0,1,0, 0,0,0,0, 32'h0, 32'h0, 32'h2222, 32'h0, 5'd9, 1, 32'h0);

    // Reset while the FSM waits for ack.
    @(posedge clk); #1;
    Memread_i = 1; Regwrite_i = 1; MemtoReg_i = 1; ALU_result_i = 32'h60;
    Reg_addr_i = 5'd5; dmem.dmem_ack_i = 0;
    @(posedge clk); #1;
    chk("busy_req", 128'({dmem.dmem_req_o, stall_o}), 128'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    clear_inputs();
    @(posedge clk); #3 rst_n = 1'b1;
    model_reset();
    run_instr(0,0,1,0, 0,0,0,0, 32'h0, 32'h0, 32'h3333, 32'h0, 5'd1, 1, 32'h0);
    run_instr(1,0,1,1, 0,0,0,0, 32'h0, 32'h0, 32'h60, 32'h0, 5'd5, 2, 32'hA5A5F00F);
    run_instr(0,0,0,0, 0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                1'($urandom), 1'($urandom),
                $urandom_range(0, 3) == 0, 1'($urandom),
                $urandom_range(0, 4) == 0, 1'($urandom),
                $urandom, $urandom, a, $urandom,
                5'($urandom), $urandom_range(1, 4), $urandom);
    end

    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk); #1;
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
